square_render: RTL and testbench

Pixel-rendering back end for the two-player square game. It consumes the square and paddle positions produced by the game-logic block together with the scan counters and syncs from the VGA timing generator, and drives the final RGB and delayed sync signals to the DAC. Positions are captured once per frame at the start of vertical blanking, so a frame never tears. The compare/colour path is a fixed 2-stage pipeline, with syncs delayed to match.

---
 rtl/vga_game_pkg.sv | 37 +++
 rtl/square_render_rect_hit.sv | 25 ++
 rtl/square_render.sv | 145 ++++++++++++++
 tb/tb_square_render.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_game_pkg.sv
// Shared constants for the two-player square game: geometry, scan limits,
// RGB565 colours and the square spawn coordinates used by game logic too.
package vga_game_pkg;

    localparam int SIDE   = 40;
    localparam int STICK  = 75;
    localparam int PAD_H  = 10;
    localparam int PAD_Y  = 462;
    localparam int PAD2_Y = 136;
    localparam int H_DISP = 800;
    localparam int V_DISP = 600;

    localparam logic [15:0] COL_SQ1 = 16'hF800;
    localparam logic [15:0] COL_SQ2 = 16'h001F;
    localparam logic [15:0] COL_PAD = 16'hFFFF;
    localparam logic [15:0] COL_BG  = 16'h0000;

    localparam logic [9:0] SQ1_RST_X = 10'd379;
    localparam logic [9:0] SQ1_RST_Y = 10'd420;
    localparam logic [9:0] SQ2_RST_X = 10'd379;
    localparam logic [9:0] SQ2_RST_Y = 10'd140;

    // Square 1 sits on top of everything, then square 2, then the paddles.
    function automatic logic [15:0] pixel_colour(input logic de,
                                                 input logic sq1,
                                                 input logic sq2,
                                                 input logic pad);
        logic [15:0] col;
        col = COL_BG;
        if (!de)      col = COL_BG;
        else if (sq1) col = COL_SQ1;
        else if (sq2) col = COL_SQ2;
        else if (pad) col = COL_PAD;
        return col;
    endfunction

endpackage

// File: rtl/square_render_rect_hit.sv
// Combinational half-open rectangle test: x0 <= h < x0+w and y0 <= v < y0+h_len.
module rect_hit (
    input  logic [10:0] h,
    input  logic [10:0] v,
    input  logic [9:0]  x0,
    input  logic [9:0]  y0,
    input  logic [10:0] w,
    input  logic [10:0] h_len,
    output logic        hit
);

    logic [10:0] w_x0;
    logic [10:0] w_y0;
    logic [10:0] w_x1;
    logic [10:0] w_y1;

    // Zero-extended 11-bit bounds; a 10-bit corner plus these sizes cannot wrap.
    assign w_x0 = {1'b0, x0};
    assign w_y0 = {1'b0, y0};
    assign w_x1 = w_x0 + w;
    assign w_y1 = w_y0 + h_len;

    assign hit = (h >= w_x0) && (h < w_x1) && (v >= w_y0) && (v < w_y1);

endmodule

// File: rtl/square_render.sv
// Pixel back end: per-frame shadowed positions, 2-stage hit/colour pipeline,
// and syncs delayed to stay aligned with rgb.
module square_render #(
    parameter int SIDE   = vga_game_pkg::SIDE,
    parameter int STICK  = vga_game_pkg::STICK,
    parameter int PAD_H  = vga_game_pkg::PAD_H,
    parameter int PAD_Y  = vga_game_pkg::PAD_Y,
    parameter int PAD2_Y = vga_game_pkg::PAD2_Y,
    parameter int H_DISP = vga_game_pkg::H_DISP,
    parameter int V_DISP = vga_game_pkg::V_DISP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] h_cnt,
    input  logic [10:0] v_cnt,
    input  logic        de,
    input  logic        hs,
    input  logic        vs,
    input  logic [9:0]  sq_x,
    input  logic [9:0]  sq_y,
    input  logic [9:0]  sq2_x,
    input  logic [9:0]  sq2_y,
    input  logic [9:0]  pad_x,
    input  logic [9:0]  pad2_x,
    output logic [15:0] rgb,
    output logic        de_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic        frame_tick
);

    import vga_game_pkg::*;

    logic [9:0]  r_sq_x, r_sq_y, r_sq2_x, r_sq2_y, r_pad_x, r_pad2_x;
    logic        r_frame_tick;
    logic        r_hit_sq1, r_hit_sq2, r_hit_pad, r_hit_pad2;
    logic        r_de1, r_hs1, r_vs1;
    logic [15:0] r_rgb;
    logic        r_de2, r_hs2, r_vs2;

    logic        w_latch;
    logic        w_hit_sq1, w_hit_sq2, w_hit_pad, w_hit_pad2;

    assign w_latch = (h_cnt == 11'd0) && (v_cnt == 11'(V_DISP));

    // Positions only move at the start of vertical blanking so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq_x       <= SQ1_RST_X;
            r_sq_y       <= SQ1_RST_Y;
            r_sq2_x      <= SQ2_RST_X;
            r_sq2_y      <= SQ2_RST_Y;
            r_pad_x      <= 10'd0;
            r_pad2_x     <= 10'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_latch;
            if (w_latch) begin
                r_sq_x   <= sq_x;
                r_sq_y   <= sq_y;
                r_sq2_x  <= sq2_x;
                r_sq2_y  <= sq2_y;
                r_pad_x  <= pad_x;
                r_pad2_x <= pad2_x;
            end
        end
    end

    rect_hit u_hit_sq1 (
        .h     (h_cnt),
        .v     (v_cnt),
        .x0    (r_sq_x),
        .y0    (r_sq_y),
        .w     (11'(SIDE)),
        .h_len (11'(SIDE)),
        .hit   (w_hit_sq1)
    );

    rect_hit u_hit_sq2 (
        .h     (h_cnt),
        .v     (v_cnt),
        .x0    (r_sq2_x),
        .y0    (r_sq2_y),
        .w     (11'(SIDE)),
        .h_len (11'(SIDE)),
        .hit   (w_hit_sq2)
    );

    rect_hit u_hit_pad (
        .h     (h_cnt),
        .v     (v_cnt),
        .x0    (r_pad_x),
        .y0    (10'(PAD_Y)),
        .w     (11'(STICK)),
        .h_len (11'(PAD_H)),
        .hit   (w_hit_pad)
    );

    rect_hit u_hit_pad2 (
        .h     (h_cnt),
        .v     (v_cnt),
        .x0    (r_pad2_x),
        .y0    (10'(PAD2_Y)),
        .w     (11'(STICK)),
        .h_len (11'(PAD_H)),
        .hit   (w_hit_pad2)
    );

    // Stage 1 registers the hit flags with the syncs; stage 2 resolves colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_sq1  <= 1'b0;
            r_hit_sq2  <= 1'b0;
            r_hit_pad  <= 1'b0;
            r_hit_pad2 <= 1'b0;
            r_de1      <= 1'b0;
            r_hs1      <= 1'b0;
            r_vs1      <= 1'b0;
            r_rgb      <= COL_BG;
            r_de2      <= 1'b0;
            r_hs2      <= 1'b0;
            r_vs2      <= 1'b0;
        end else begin
            r_hit_sq1  <= w_hit_sq1;
            r_hit_sq2  <= w_hit_sq2;
            r_hit_pad  <= w_hit_pad;
            r_hit_pad2 <= w_hit_pad2;
            r_de1      <= de;
            r_hs1      <= hs;
            r_vs1      <= vs;
            r_rgb      <= pixel_colour(r_de1, r_hit_sq1, r_hit_sq2,
                                       r_hit_pad | r_hit_pad2);
            r_de2      <= r_de1;
            r_hs2      <= r_hs1;
            r_vs2      <= r_vs1;
        end
    end

    assign rgb        = r_rgb;
    assign de_o       = r_de2;
    assign hs_o       = r_hs2;
    assign vs_o       = r_vs2;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_square_render.sv
// Scoreboard bench for square_render: the driver queues hand-computed pixels,
// a monitor pops and compares them two cycles after each is sampled.
module tb_square_render;

    logic        clk;
    logic        rst_n;
    logic [10:0] h_cnt, v_cnt;
    logic        de, hs, vs;
    logic [9:0]  sq_x, sq_y, sq2_x, sq2_y, pad_x, pad2_x;
    logic [15:0] rgb;
    logic        de_o, hs_o, vs_o, frame_tick;

    typedef struct {
        int          idx;
        logic [15:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        string       name;
    } exp_t;

    exp_t q[$];
    int   pcnt  = 0;
    int   tests = 0;
    int   fails = 0;

    square_render dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .de         (de),
        .hs         (hs),
        .vs         (vs),
        .sq_x       (sq_x),
        .sq_y       (sq_y),
        .sq2_x      (sq2_x),
        .sq2_y      (sq2_y),
        .pad_x      (pad_x),
        .pad2_x     (pad2_x),
        .rgb        (rgb),
        .de_o       (de_o),
        .hs_o       (hs_o),
        .vs_o       (vs_o),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: the pixel sampled at posedge p is on the outputs after posedge p+1.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            pcnt++;
            #1;
            while (q.size() > 0 && q[0].idx + 1 <= pcnt) begin
                e = q.pop_front();
                tests++;
                if (e.idx + 1 != pcnt || rgb !== e.rgb || de_o !== e.de ||
                    hs_o !== e.hs || vs_o !== e.vs) begin
                    fails++;
                    $display("[TB] FAIL %s: got rgb=%h de=%b hs=%b vs=%b, expected rgb=%h de=%b hs=%b vs=%b",
                             e.name, rgb, de_o, hs_o, vs_o, e.rgb, e.de, e.hs, e.vs);
                end
            end
        end
    end

    task automatic applyStimulus(input int h, input int v, input logic d,
                                 input logic hsync, input logic vsync,
                                 input logic [15:0] expRgb, input string name);
        exp_t e;
        @(negedge clk);
        h_cnt = 11'(h);
        v_cnt = 11'(v);
        de    = d;
        hs    = hsync;
        vs    = vsync;
        e.idx  = pcnt + 1;
        e.rgb  = expRgb;
        e.de   = d;
        e.hs   = hsync;
        e.vs   = vsync;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic checkOutput(input logic [15:0] expRgb, input logic expDe,
                               input logic expHs, input logic expVs,
                               input logic expTick, input string name);
        tests++;
        if (rgb !== expRgb || de_o !== expDe || hs_o !== expHs ||
            vs_o !== expVs || frame_tick !== expTick) begin
            fails++;
            $display("[TB] FAIL %s: got rgb=%h de=%b hs=%b vs=%b tick=%b, expected rgb=%h de=%b hs=%b vs=%b tick=%b",
                     name, rgb, de_o, hs_o, vs_o, frame_tick,
                     expRgb, expDe, expHs, expVs, expTick);
        end
    endtask

    task automatic checkTick(input logic expTick, input string name);
        tests++;
        if (frame_tick !== expTick) begin
            fails++;
            $display("[TB] FAIL %s: got frame_tick=%b, expected %b", name, frame_tick, expTick);
        end
    endtask

    task automatic setPositions(input int x1, input int y1, input int x2,
                                input int y2, input int px, input int p2x);
        sq_x   = 10'(x1);
        sq_y   = 10'(y1);
        sq2_x  = 10'(x2);
        sq2_y  = 10'(y2);
        pad_x  = 10'(px);
        pad2_x = 10'(p2x);
    endtask

    // Drive the latch point and confirm frame_tick is a single-cycle pulse.
    task automatic latchFrame(input string name);
        applyStimulus(0, 600, 1'b0, 1'b0, 1'b1, 16'h0000, {name, " latch"});
        checkTick(1'b0, {name, " tick before"});
        applyStimulus(1, 600, 1'b0, 1'b1, 1'b1, 16'h0000, {name, " post1"});
        checkTick(1'b1, {name, " tick pulse"});
        applyStimulus(2, 600, 1'b0, 1'b0, 1'b0, 16'h0000, {name, " post2"});
        checkTick(1'b0, {name, " tick after"});
    endtask

    initial begin
        rst_n = 1'b0;
        h_cnt = '0;
        v_cnt = '0;
        de    = 1'b0;
        hs    = 1'b0;
        vs    = 1'b0;
        setPositions(0, 0, 0, 0, 0, 0);
        #7;
        checkOutput(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "power-on reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset shadows: sq1 (379,420), sq2 (379,140), paddles at x=0.
        applyStimulus(378, 420, 1'b1, 1'b0, 1'b0, 16'h0000, "left of sq1");
        applyStimulus(379, 420, 1'b1, 1'b1, 1'b0, 16'hF800, "sq1 corner");
        applyStimulus(418, 420, 1'b1, 1'b0, 1'b1, 16'hF800, "sq1 last col");
        applyStimulus(419, 420, 1'b1, 1'b1, 1'b1, 16'h0000, "sq1 past col");
        applyStimulus(418, 459, 1'b1, 1'b0, 1'b0, 16'hF800, "sq1 last row");
        applyStimulus(418, 460, 1'b1, 1'b0, 1'b0, 16'h0000, "sq1 past row");
        applyStimulus(379, 140, 1'b1, 1'b1, 1'b0, 16'h001F, "sq2 corner");
        applyStimulus(418, 179, 1'b1, 1'b0, 1'b0, 16'h001F, "sq2 far corner");
        applyStimulus(379, 180, 1'b1, 1'b0, 1'b1, 16'h0000, "sq2 below");
        applyStimulus(0, 136, 1'b1, 1'b0, 1'b0, 16'hFFFF, "pad2 corner");
        applyStimulus(74, 145, 1'b1, 1'b1, 1'b0, 16'hFFFF, "pad2 far corner");
        applyStimulus(75, 140, 1'b1, 1'b0, 1'b0, 16'h0000, "pad2 right");
        applyStimulus(10, 146, 1'b1, 1'b0, 1'b0, 16'h0000, "pad2 below");
        applyStimulus(0, 462, 1'b1, 1'b0, 1'b1, 16'hFFFF, "pad corner");
        applyStimulus(74, 471, 1'b1, 1'b0, 1'b0, 16'hFFFF, "pad far corner");
        applyStimulus(10, 472, 1'b1, 1'b0, 1'b0, 16'h0000, "pad below");
        applyStimulus(10, 461, 1'b1, 1'b0, 1'b0, 16'h0000, "pad above");

        // Fill the pipeline with red and syncs high, then reset mid-line.
        applyStimulus(380, 421, 1'b1, 1'b1, 1'b1, 16'hF800, "pre-reset a");
        applyStimulus(381, 421, 1'b1, 1'b1, 1'b1, 16'hF800, "pre-reset b");
        applyStimulus(382, 421, 1'b1, 1'b1, 1'b1, 16'hF800, "pre-reset c");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "mid-line reset");
        q.delete();
        repeat (2) @(negedge clk);
        checkOutput(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "reset held");
        rst_n = 1'b1;
        applyStimulus(379, 420, 1'b1, 1'b0, 1'b1, 16'hF800, "refill sq1");
        applyStimulus(379, 140, 1'b1, 1'b1, 1'b0, 16'h001F, "refill sq2");

        // Priority: sq1 over sq2 over top paddle, stripping one layer per frame.
        setPositions(100, 130, 100, 130, 0, 90);
        latchFrame("prio1");
        applyStimulus(110, 140, 1'b1, 1'b0, 1'b0, 16'hF800, "prio sq1 top");
        applyStimulus(95, 140, 1'b1, 1'b1, 1'b0, 16'hFFFF, "prio pad2 only");
        setPositions(500, 300, 100, 130, 0, 90);
        latchFrame("prio2");
        applyStimulus(110, 140, 1'b1, 1'b0, 1'b1, 16'h001F, "prio sq2 top");
        setPositions(500, 300, 600, 300, 0, 90);
        latchFrame("prio3");
        applyStimulus(110, 140, 1'b1, 1'b0, 1'b0, 16'hFFFF, "prio pad2 top");

        // Frame atomicity: the new sq_y only shows after the next latch.
        setPositions(500, 200, 600, 300, 0, 90);
        applyStimulus(500, 300, 1'b1, 1'b0, 1'b0, 16'hF800, "old frame top");
        applyStimulus(539, 339, 1'b1, 1'b1, 1'b0, 16'hF800, "old frame corner");
        applyStimulus(540, 339, 1'b1, 1'b0, 1'b0, 16'h0000, "old frame right");
        applyStimulus(500, 200, 1'b1, 1'b0, 1'b0, 16'h0000, "new row not yet");
        latchFrame("atom");
        applyStimulus(500, 200, 1'b1, 1'b0, 1'b1, 16'hF800, "new frame top");
        applyStimulus(539, 239, 1'b1, 1'b0, 1'b0, 16'hF800, "new frame corner");
        applyStimulus(500, 240, 1'b1, 1'b1, 1'b0, 16'h0000, "new frame below");
        applyStimulus(500, 300, 1'b1, 1'b0, 1'b0, 16'h0000, "old row gone");

        // Right-edge clip: square straddles column 800, blanking beyond.
        setPositions(790, 200, 600, 300, 0, 90);
        latchFrame("clip");
        applyStimulus(789, 210, 1'b1, 1'b0, 1'b0, 16'h0000, "clip left");
        applyStimulus(790, 210, 1'b1, 1'b0, 1'b0, 16'hF800, "clip first col");
        applyStimulus(799, 210, 1'b1, 1'b1, 1'b0, 16'hF800, "clip last vis");
        applyStimulus(800, 210, 1'b0, 1'b1, 1'b0, 16'h0000, "clip h800");
        applyStimulus(829, 210, 1'b0, 1'b0, 1'b1, 16'h0000, "clip h829");
        applyStimulus(0, 210, 1'b1, 1'b0, 1'b0, 16'h0000, "no wrap col0");
        applyStimulus(3, 210, 1'b1, 1'b0, 1'b0, 16'h0000, "no wrap col3");

        // Blanking override inside the square while syncs keep toggling.
        applyStimulus(795, 210, 1'b0, 1'b1, 1'b0, 16'h0000, "blank hs1");
        applyStimulus(796, 215, 1'b0, 1'b0, 1'b1, 16'h0000, "blank vs1");
        applyStimulus(797, 220, 1'b0, 1'b1, 1'b1, 16'h0000, "blank both");
        applyStimulus(798, 225, 1'b1, 1'b0, 1'b0, 16'hF800, "unblank");

        repeat (4) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
